heap_memory: RTL

Parametrised heap of fixed-length arrays for the fpga test programs. It is the successor to the action-decoded heap stub that only handled reset. Programs issue one action per request: allocate, free, read, write, push, pop, size, clear. The block tracks ownership and per-array size, checks bounds, and returns data with a done/error handshake. It sits between the program sequencer in fpga and a single-port data store of ARRAYS×ARRAY_LENGTH words.

---
 rtl/heap_memory_if.sv | 27 ++
 rtl/heap_memory.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/heap_memory_if.sv
// Request/response bus between the program sequencer and the heap.
interface heap_memory_if #(
  parameter int AB        = 4,
  parameter int IB        = 3,
  parameter int DATA_BITS = 12
);
  logic                 start;
  logic [3:0]           action;
  logic [AB-1:0]        array;
  logic [IB-1:0]        index;
  logic [DATA_BITS-1:0] inData;
  logic                 ready;
  logic                 done;
  logic                 error;
  logic [DATA_BITS-1:0] outData;
  logic [AB:0]          allocated;

  modport master (
    output start, action, array, index, inData,
    input  ready, done, error, outData, allocated
  );

  modport slave (
    input  start, action, array, index, inData,
    output ready, done, error, outData, allocated
  );
endinterface

// File: rtl/heap_memory.sv
// Heap of fixed-length arrays: ownership bitmap, per-array size, bounds
// checks and a registered-read data store behind a done/error handshake.
module heap_memory #(
  parameter int ARRAYS       = 16,
  parameter int ARRAY_LENGTH = 8,
  parameter int DATA_BITS    = 12
) (
  input  logic          clock,
  input  logic          reset,
  heap_memory_if.slave  bus
);
  localparam int AB = $clog2(ARRAYS);
  localparam int IB = $clog2(ARRAY_LENGTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_RESET = 4'd1;
  localparam logic [3:0] OP_ALLOC = 4'd2;
  localparam logic [3:0] OP_FREE  = 4'd3;
  localparam logic [3:0] OP_READ  = 4'd4;
  localparam logic [3:0] OP_WRITE = 4'd5;
  localparam logic [3:0] OP_SIZE  = 4'd6;
  localparam logic [3:0] OP_PUSH  = 4'd7;
  localparam logic [3:0] OP_POP   = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, RDATA} state_t;
  state_t state, state_next;

  logic [ARRAYS-1:0]    in_use;
  logic [IB:0]          size [ARRAYS];
  logic [DATA_BITS-1:0] mem [ARRAYS*ARRAY_LENGTH];
  logic [AB:0]          alloc_count;
  logic                 done_flag, error_flag;
  logic [DATA_BITS-1:0] result;

  logic [3:0]           act_p0;
  logic [AB-1:0]        arr_p0;
  logic [IB-1:0]        idx_p0;
  logic [DATA_BITS-1:0] din_p0;
  logic [DATA_BITS-1:0] rdata_p1;
  logic                 rd_err_p1;

  logic                 err, is_rd, wr_en, free_found;
  logic [AB-1:0]        free_idx;
  logic [IB:0]          sz, sz_dec, idx_inc;
  logic [AB+IB-1:0]     wr_addr, rd_addr;
  logic [DATA_BITS-1:0] res;

  assign bus.ready     = (state == IDLE);
  assign bus.done      = done_flag;
  assign bus.error     = error_flag;
  assign bus.outData   = result;
  assign bus.allocated = alloc_count;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: READ/POP take an extra cycle for the registered store read
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = EXEC;
      EXEC:    state_next = is_rd ? RDATA : IDLE;
      RDATA:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode of the latched request: error, result and store addresses
  always_comb begin
    sz         = size[arr_p0];
    sz_dec     = sz - (IB+1)'(1);
    idx_inc    = {1'b0, idx_p0} + (IB+1)'(1);
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        free_found = 1'b1;
        free_idx   = AB'(i);
      end
    end
    err = 1'b0;
    res = '0;
    case (act_p0)
      OP_NOP, OP_RESET: err = 1'b0;
      OP_ALLOC: begin
        err = !free_found;
        res = DATA_BITS'(free_idx);
      end
      OP_FREE, OP_WRITE, OP_CLEAR: err = !in_use[arr_p0];
      OP_READ:  err = !in_use[arr_p0] || ({1'b0, idx_p0} >= sz);
      OP_SIZE: begin
        err = !in_use[arr_p0];
        res = DATA_BITS'(sz);
      end
      OP_PUSH:  err = !in_use[arr_p0] || (sz == (IB+1)'(ARRAY_LENGTH));
      OP_POP:   err = !in_use[arr_p0] || (sz == '0);
      default:  err = 1'b1;
    endcase
    if (err) res = '0;
    is_rd   = (act_p0 == OP_READ) || (act_p0 == OP_POP);
    wr_en   = !err && ((act_p0 == OP_WRITE) || (act_p0 == OP_PUSH));
    wr_addr = {arr_p0, (act_p0 == OP_WRITE) ? idx_p0 : sz[IB-1:0]};
    rd_addr = {arr_p0, (act_p0 == OP_READ) ? idx_p0 : sz_dec[IB-1:0]};
  end

  // Stage 0: capture the request on acceptance
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.start) begin
      act_p0 <= bus.action;
      arr_p0 <= bus.array;
      idx_p0 <= bus.index;
      din_p0 <= bus.inData;
    end
  end

  // Stage 1: store write/read; a reset in this cycle aborts the write
  always_ff @(posedge clock) begin
    if (state == EXEC) begin
      if (wr_en && !reset) mem[wr_addr] <= din_p0;
      rdata_p1  <= mem[rd_addr];
      rd_err_p1 <= err;
    end
  end

  // Bookkeeping commit and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      in_use      <= '0;
      for (int i = 0; i < ARRAYS; i++) size[i] <= '0;
      alloc_count <= '0;
      done_flag   <= 1'b0;
      error_flag  <= 1'b0;
      result      <= '0;
    end else begin
      done_flag <= 1'b0;
      if (state == EXEC) begin
        if (!is_rd) begin
          done_flag  <= 1'b1;
          error_flag <= err;
          result     <= res;
        end
        if (!err) begin
          case (act_p0)
            OP_RESET: begin
              in_use      <= '0;
              for (int i = 0; i < ARRAYS; i++) size[i] <= '0;
              alloc_count <= '0;
            end
            OP_ALLOC: begin
              in_use[free_idx] <= 1'b1;
              size[free_idx]   <= '0;
              alloc_count      <= alloc_count + (AB+1)'(1);
            end
            OP_FREE: begin
              in_use[arr_p0] <= 1'b0;
              alloc_count    <= alloc_count - (AB+1)'(1);
            end
            OP_WRITE: if (idx_inc > sz) size[arr_p0] <= idx_inc;
            OP_PUSH:  size[arr_p0] <= sz + (IB+1)'(1);
            OP_POP:   size[arr_p0] <= sz_dec;
            OP_CLEAR: size[arr_p0] <= '0;
            default:  ;
          endcase
        end
      end else if (state == RDATA) begin
        done_flag  <= 1'b1;
        error_flag <= rd_err_p1;
        result     <= rd_err_p1 ? '0 : rdata_p1;
      end
    end
  end
endmodule
